// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: byte width and FSM state encoding.
package spi_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/spi_byte_fifo.sv
// Byte FIFO with first-word-fall-through head; pushes when full and pops when empty are dropped.
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LW-1:0]     o_level
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == {LW{1'b0}});
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array, written only on an accepted push.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and fill level; push and pop in the same cycle leave the level unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Feeds buffered TX bytes to an SPI byte master one at a time under a single chip-select
// transaction and collects the returned bytes into an RX FIFO.
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH       = 4,
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_wr_byte,
  input  logic              i_wr_en,
  output logic              o_wr_full,
  input  logic              i_start,
  input  logic [CW-1:0]     i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [BYTE_W-1:0] o_rd_byte,
  input  logic              i_rd_en,
  output logic              o_rd_empty,
  output logic              o_rx_ovf,
  output logic [CW-1:0]     o_TX_count,
  output logic [BYTE_W-1:0] o_TX_Byte,
  output logic              o_TX_DV,
  input  logic              i_TX_Ready,
  input  logic              i_RX_DV,
  input  logic [BYTE_W-1:0] i_RX_Byte
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_tx_count;
  logic [CW-1:0]     r_remaining;
  logic              r_err;
  logic              r_rx_ovf;
  logic              w_len_ok;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_tx_dv;
  logic              w_rx_get;
  logic [BYTE_W-1:0] w_tx_head;
  logic              w_tx_empty;
  logic [LW-1:0]     w_tx_level;
  logic              w_rx_full;
  logic [LW-1:0]     w_rx_level_unused;

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_wr_en),
    .i_data  (i_wr_byte),
    .i_pop   (w_tx_dv),
    .o_data  (w_tx_head),
    .o_full  (o_wr_full),
    .o_empty (w_tx_empty),
    .o_level (w_tx_level)
  );

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_rx_get),
    .i_data  (i_RX_Byte),
    .i_pop   (i_rd_en),
    .o_data  (o_rd_byte),
    .o_full  (w_rx_full),
    .o_empty (o_rd_empty),
    .o_level (w_rx_level_unused)
  );

  // A start is only accepted when every byte of the transaction is already buffered.
  assign w_len_ok = (i_len != {CW{1'b0}})
                 && (32'(i_len) <= $unsigned(MAX_BYTES_PER_CS))
                 && (32'(w_tx_level) >= 32'(i_len));

  assign o_TX_DV    = w_tx_dv;
  assign o_TX_Byte  = w_tx_dv ? w_tx_head : {BYTE_W{1'b0}};
  assign o_TX_count = r_tx_count;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_err      = r_err;
  assign o_rx_ovf   = r_rx_ovf;

  // Next-state and per-cycle strobes.
  always_comb begin
    w_next      = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_tx_dv     = 1'b0;
    w_rx_get    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && w_len_ok) begin
          w_start_ok = 1'b1;
          w_next     = ST_ISSUE;
        end else if (i_start) begin
          w_start_bad = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_TX_Ready && !w_tx_empty) begin
          w_tx_dv = 1'b1;
          w_next  = ST_WAIT_RX;
        end else begin
          w_next = ST_ISSUE;
        end
      end
      ST_WAIT_RX: begin
        if (i_RX_DV) begin
          w_rx_get = 1'b1;
          w_next   = (r_remaining == CW'(1)) ? ST_DONE : ST_ISSUE;
        end else begin
          w_next = ST_WAIT_RX;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, transaction counters, error pulse and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_tx_count  <= {CW{1'b0}};
      r_remaining <= {CW{1'b0}};
      r_err       <= 1'b0;
      r_rx_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_start_bad;
      if (w_start_ok) begin
        r_tx_count  <= i_len;
        r_remaining <= i_len;
      end else if (w_rx_get) begin
        r_remaining <= r_remaining - CW'(1);
      end
      if (w_rx_get && w_rx_full) begin
        r_rx_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entries per byte FIFO; power of 2, at least 2.
REQ-002 Parameter MAX_BYTES_PER_CS, default 2, maximum bytes per chip-select transaction; must match the SPI master's value.
REQ-003 Parameter CW, default $clog2(MAX_BYTES_PER_CS+1), width of the length and count fields.
REQ-004 i_clk  in  1  sole clock; one clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_wr_byte  in  8  host TX byte; i_wr_en  in  1  push strobe; o_wr_full  out  1  TX FIFO full.
REQ-007 i_start  in  1  start-transaction pulse; i_len  in  CW  bytes in transaction.
REQ-008 o_busy  out  1  transaction active; o_done  out  1  one-cycle completion pulse; o_err  out  1  one-cycle rejected-start pulse.
REQ-009 o_rd_byte  out  8  RX FIFO head; i_rd_en  in  1  pop strobe; o_rd_empty  out  1  RX FIFO empty; o_rx_ovf  out  1  sticky RX overflow.
REQ-010 o_TX_count  out  CW  to master: bytes this CS; o_TX_Byte  out  8  to master; o_TX_DV  out  1  to master.
REQ-011 i_TX_Ready  in  1  from master; i_RX_DV  in  1  from master; i_RX_Byte  in  8  from master.

Function
REQ-012 A TX FIFO push (i_wr_en=1, not full) SHALL land in the same cycle; a push while full SHALL be ignored.
REQ-013 An RX FIFO pop (i_rd_en=1, not empty) SHALL advance the head; o_rd_byte is first-word-fall-through; a pop while empty SHALL be ignored.
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT_RX, DONE.
REQ-015 IDLE: i_start with 1<=i_len<=MAX_BYTES_PER_CS and TX level>=i_len SHALL latch i_len into o_TX_count and a remaining counter, and enter ISSUE next cycle.
REQ-016 IDLE: any other i_start SHALL produce o_err=1 for one cycle, remain in IDLE, and consume no FIFO data.
REQ-017 ISSUE: when i_TX_Ready=1, the block SHALL drive o_TX_DV=1 for exactly one cycle with o_TX_Byte set to the TX head, pop the TX FIFO, and enter WAIT_RX.
REQ-018 WAIT_RX: o_TX_DV SHALL stay 0 regardless of i_TX_Ready; on i_RX_DV=1, i_RX_Byte SHALL be pushed to the RX FIFO and remaining decremented.
REQ-019 WAIT_RX: when remaining reaches 0, go to DONE; otherwise return to ISSUE.
REQ-020 DONE: o_done=1 for one cycle, then IDLE.
REQ-021 i_RX_DV arriving with the RX FIFO full SHALL drop the byte and set o_rx_ovf, which holds until reset.
REQ-022 A simultaneous RX push and host pop SHALL both take effect; a simultaneous host TX push and ISSUE pop SHALL both take effect.
REQ-023 i_start outside IDLE SHALL be ignored (no o_err).
REQ-024 o_busy SHALL be 1 in ISSUE, WAIT_RX and DONE, and 0 otherwise.
REQ-025 o_TX_count SHALL hold its value from start until the next accepted start.
REQ-026 i_RX_DV in IDLE SHALL be ignored.

Reset
REQ-027 i_rst at any point, including mid-transaction, SHALL force IDLE at the next edge.
REQ-028 Reset SHALL flush both FIFOs and clear the counter and o_rx_ovf.
REQ-029 Reset values: o_TX_DV=0, o_TX_Byte=0, o_TX_count=0, o_busy=0, o_done=0, o_err=0, o_wr_full=0, o_rd_empty=1, o_rx_ovf=0.

Structure
REQ-030 A shared package spi_pkg SHALL hold the FSM state typedef and the byte-width constant (8).
REQ-031 A single sub-module, spi_byte_fifo (parameter DEPTH; push/pop/full/empty/level), SHALL be instantiated twice (TX, RX).

Verification
REQ-032 Push 0xFF and 0x88, start len=2, master in MOSI-MISO loopback -> two o_TX_DV pulses (0xFF then 0x88), o_done once, RX reads 0xFF then 0x88.
REQ-033 Push one byte, start len=2 -> o_err pulse, o_busy stays 0, TX level stays 1.
REQ-034 Start len=0, and start len=3 with MAX_BYTES_PER_CS=2 -> o_err each time, no o_TX_DV.
REQ-035 Fill RX FIFO (4 bytes, no reads), run a 1-byte transaction -> o_rx_ovf=1, RX contents unchanged.
REQ-036 Assert i_rst during WAIT_RX of a 2-byte transaction -> next cycle o_busy=0, o_TX_DV=0, o_rd_empty=1, no o_done.
REQ-037 Hold i_TX_Ready=1 throughout WAIT_RX -> no second o_TX_DV before i_RX_DV.
